// File: rtl/uart_rx_frame_sampler_if.sv
// RX line, baud tick and frame config in; received byte and per-frame status pulses out.
// master = frame sampler, slave = downstream consumer (error manager) that also drives the line side.
interface uart_rx_frame_sampler_if;
  logic       rx_in;
  logic       baud_tick_16x;
  logic [1:0] data_bits;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_active;
  logic       bit_valid;
  logic       rx_filtered;
  logic       frame_error;
  logic       parity_error;

  modport master (
    input  rx_in, baud_tick_16x, data_bits, parity_en, parity_odd, two_stop,
    output rx_data, rx_valid, frame_active, bit_valid, rx_filtered, frame_error, parity_error
  );

  modport slave (
    output rx_in, baud_tick_16x, data_bits, parity_en, parity_odd, two_stop,
    input  rx_data, rx_valid, frame_active, bit_valid, rx_filtered, frame_error, parity_error
  );
endinterface

// File: rtl/uart_rx_frame_sampler.sv
// UART RX front end: start detect, 3-sample majority vote at 16x, 5-8 data bits, parity, 1-2 stop bits.
// rx_valid lands 9 ticks into the final stop bit; no backpressure, every status output is a one-clk pulse.
module uart_rx_frame_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int VOTE_CENTER = 8
) (
  input logic                     clk,
  input logic                     rst,
  uart_rx_frame_sampler_if.master bus
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] T_LO      = 4'(VOTE_CENTER - 1);
  localparam logic [3:0] T_MID     = 4'(VOTE_CENTER);
  localparam logic [3:0] T_HI      = 4'(VOTE_CENTER + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t     state;
  logic [3:0] tick_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       s_lo;
  logic       s_mid;
  logic       rx_prev;
  logic       stop_cnt;
  logic       fe_done;
  logic [1:0] cfg_bits;
  logic       cfg_par;
  logic       cfg_odd;
  logic       cfg_two;

  logic decide;
  logic wrap;
  logic vote;
  logic last_data;
  logic last_stop;

  always_comb begin
    decide    = bus.baud_tick_16x && (tick_cnt == T_HI);
    wrap      = bus.baud_tick_16x && (tick_cnt == LAST_TICK);
    vote      = (s_lo & s_mid) | (s_lo & bus.rx_in) | (s_mid & bus.rx_in);
    last_data = (bit_cnt == ({2'b00, cfg_bits} + 4'd5));
    last_stop = !cfg_two || stop_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tick_cnt         <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      s_lo             <= 1'b1;
      s_mid            <= 1'b1;
      rx_prev          <= 1'b0;  // forces the line to be seen high before a start can arm
      stop_cnt         <= 1'b0;
      fe_done          <= 1'b0;
      cfg_bits         <= '0;
      cfg_par          <= 1'b0;
      cfg_odd          <= 1'b0;
      cfg_two          <= 1'b0;
      bus.rx_data      <= '0;
      bus.rx_valid     <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.bit_valid    <= 1'b0;
      bus.rx_filtered  <= 1'b1;
      bus.frame_error  <= 1'b0;
      bus.parity_error <= 1'b0;
    end else begin
      rx_prev          <= bus.rx_in;
      bus.rx_valid     <= 1'b0;
      bus.bit_valid    <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.parity_error <= 1'b0;
      if (bus.rx_valid) bus.frame_active <= 1'b0;

      if (state != IDLE && state != WAIT_IDLE && bus.baud_tick_16x) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == T_LO)  s_lo  <= bus.rx_in;
        if (tick_cnt == T_MID) s_mid <= bus.rx_in;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !bus.rx_in) begin
            state            <= START;
            tick_cnt         <= '0;
            bus.frame_active <= 1'b1;
            bit_cnt          <= '0;
            shreg            <= '0;
            stop_cnt         <= 1'b0;
            fe_done          <= 1'b0;
            cfg_bits         <= bus.data_bits;
            cfg_par          <= bus.parity_en;
            cfg_odd          <= bus.parity_odd;
            cfg_two          <= bus.two_stop;
          end
        end
        START: begin
          if (decide) begin
            if (vote) begin
              state            <= IDLE;
              bus.frame_active <= 1'b0;
            end else begin
              bus.bit_valid   <= 1'b1;
              bus.rx_filtered <= 1'b0;
            end
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) begin
            shreg[bit_cnt[2:0]] <= vote;
            bit_cnt             <= bit_cnt + 4'd1;
            bus.bit_valid       <= 1'b1;
            bus.rx_filtered     <= vote;
          end else if (wrap && last_data) begin
            state <= cfg_par ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (decide) begin
            bus.bit_valid   <= 1'b1;
            bus.rx_filtered <= vote;
            if (vote != (^shreg ^ cfg_odd)) bus.parity_error <= 1'b1;
          end else if (wrap) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            bus.bit_valid   <= 1'b1;
            bus.rx_filtered <= vote;
            if (!vote && !fe_done) begin
              bus.frame_error <= 1'b1;
              fe_done         <= 1'b1;
            end
            // Re-arm at mid stop bit so back-to-back frames can resync on the next start edge.
            if (last_stop) begin
              bus.rx_data  <= shreg;
              bus.rx_valid <= 1'b1;
              state        <= vote ? IDLE : WAIT_IDLE;
            end
          end else if (wrap) begin
            stop_cnt <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (bus.rx_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_frame_sampler.md
Name: uart_rx_frame_sampler

Overview:
UART receive front end that sits directly upstream of the RX error manager. It detects start bits on the synchronized RX line and majority-votes each bit at 16x oversampling. It assembles 5-8 data bits (LSB first), checks optional parity and 1-2 stop bits, and emits the received byte. It also produces the per-frame status pulses (frame_active, bit_valid, rx_filtered, frame_error, parity_error) that the error manager consumes.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; fixed at 16, other values unsupported.
VOTE_CENTER, 8, tick index at the bit centre; samples are taken at VOTE_CENTER-1, VOTE_CENTER and VOTE_CENTER+1.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
rx_in  input  1  RX line, already 2-FF synchronized externally; idle high.
baud_tick_16x  input  1  one-clk enable pulse at 16x the baud rate.
data_bits  input  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
parity_en  input  1  a parity bit follows the data.
parity_odd  input  1  1=odd parity, 0=even parity.
two_stop  input  1  1=two stop bits, 0=one stop bit.
rx_data  output  8  received byte; unused upper bits are 0.
rx_valid  output  1  one-clk pulse when rx_data is updated.
frame_active  output  1  high while a frame is being received.
bit_valid  output  1  one-clk pulse at each bit decision.
rx_filtered  output  1  majority-voted value of the last decided bit.
frame_error  output  1  one-clk pulse when a stop bit is sampled low.
parity_error  output  1  one-clk pulse on a parity mismatch.

Behaviour:
- Clock domain and reset: all logic is on clk.
- Reset values: rst forces, asynchronously, state=IDLE, counters 0, rx_data=0, rx_filtered=1, and all pulse outputs and frame_active to 0.
- Reset mid-frame: the frame is abandoned with no pulses. After release the block waits for rx_in high before arming start detection again.
- Config sampling: data_bits, parity_en, parity_odd and two_stop are captured at start detection. Changes during a frame have no effect until the next frame.
- Tick counter: tick_cnt (4 bits) advances only on baud_tick_16x. It wraps 15->0, and each wrap advances to the next bit.
- Bit decision: the bit value is the majority of the samples taken at ticks 7, 8 and 9. The decision is made on the tick-9 edge. In the same cycle bit_valid pulses and rx_filtered takes the voted value.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on a 1->0 edge of rx_in (registered previous value), go to START with tick_cnt=0 and frame_active=1. The edge is detected on any clk, independent of the tick.
- START: at the decision, a voted 1 is a false start: return to IDLE with frame_active=0 and no bit_valid. A voted 0 gives bit_valid=1 and rx_filtered=0, then DATA at the next wrap.
- DATA: shift in LSB first and count bits. After data_bits+5 decisions, go to PARITY if parity_en, else to STOP, at the wrap.
- PARITY: expected value is XOR(data) XOR parity_odd. On mismatch, parity_error pulses in the decision cycle. Then go to STOP at the wrap.
- STOP: a voted 0 makes frame_error pulse in that stop bit's decision cycle.
- STOP, two_stop=1: both stop bits are checked, and frame_error pulses at most once per frame.
- Final stop decision (the same cycle as its bit_valid):
  - rx_data is updated and rx_valid pulses, even when errors were flagged.
  - frame_active falls to 0 one cycle later.
  - The next state is IDLE if the last stop bit voted 1, else WAIT_IDLE.
  - Re-arm happens at mid stop bit so the block can resync.
- WAIT_IDLE: new starts are ignored until rx_in is seen high on a clk, then go to IDLE. This prevents a line break from re-triggering the receiver.
- Latency: rx_valid arrives 9 ticks into the final stop bit, i.e. (start edge + (1+N+P+S-1)*16 + 9) ticks.
- Pulse simultaneity:
  - A single clk can carry bit_valid, rx_valid and frame_error together.
  - parity_error and frame_error never coincide, because they are decided in different bits.
  - rx_valid and the pulses are never held longer than one clk.
- No baud_tick_16x: the FSM holds its state indefinitely. frame_active stays high until ticks resume.

Test Plan:
- 8N1, byte 0xA5, clean line, 16 ticks per bit:
  - rx_valid=1 once with rx_data=0xA5.
  - 10 bit_valid pulses.
  - frame_error=0 and parity_error=0.
  - frame_active high from the start edge to one cycle after the stop decision.
- 7E1, byte 0x41 sent with a wrong parity bit 1:
  - parity_error pulses once, at the 9th bit_valid.
  - rx_valid pulses with rx_data=0x41.
- False start: a low glitch of 4 ticks, then high:
  - no bit_valid, no rx_valid, frame_active returns to 0.
  - A following 0x3C frame is received correctly.
- Break: line held low for 20 bit times, 8N1:
  - 10 bit_valid pulses with rx_filtered=0.
  - frame_error=1 once, rx_valid with rx_data=0x00.
  - No further frames until the line goes high. A 0x55 frame sent after release is received correctly.
- Single-tick noise: byte 0xF0 with one inverted sample at tick 8 of each bit:
  - majority vote still yields 0xF0 and no errors.
- rst asserted in the 4th data bit of a frame:
  - all outputs go to reset values immediately, with no rx_valid.
  - With the line high after release, a subsequent 5O2 frame of 0x15 yields rx_data=0x15 and no errors.
